// File: rtl/fpu_32_pkg.sv
// Shared constants, flag layout and FSM states for the binary32 FPU datapath blocks.
package fpu_32_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int QUOT_W = 26;  // integer bit + 23 fraction bits + guard + one spare

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Bit positions inside the 4-bit flags word {invalid, div_by_zero, overflow, underflow}.
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_ROUND,
    ST_DONE
  } div_state_e;

  // Place individual exception bits at their flag positions.
  function automatic logic [3:0] pack_flags(input logic inv, input logic dz,
                                            input logic ovf, input logic unf);
    logic [3:0] f;
    f                 = '0;
    f[FLAG_INVALID]   = inv;
    f[FLAG_DIV_ZERO]  = dz;
    f[FLAG_OVERFLOW]  = ovf;
    f[FLAG_UNDERFLOW] = unf;
    return f;
  endfunction

endpackage

// File: rtl/fpu_32_div_round.sv
// Normalise a 26-bit quotient, round to nearest even and pack a binary32 result.
// Overflow saturates to signed infinity, underflow flushes to signed zero.
module fpu_32_div_round
  import fpu_32_pkg::*;
(
  input  logic                sign_i,
  input  logic [QUOT_W-1:0]   quot_i,
  input  logic                sticky_i,
  input  logic signed [9:0]   exp_i,     // exponent assuming the quotient's integer bit is set
  output logic [31:0]         result_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  logic [MAN_W-1:0]  frac;
  logic [MAN_W-1:0]  frac_rnd;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic              carry;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;

  // Select the 24-bit window, round to nearest even and range-check the exponent.
  always_comb begin
    if (quot_i[QUOT_W-1]) begin
      frac   = quot_i[24:2];
      guard  = quot_i[1];
      sticky = quot_i[0] | sticky_i;
      exp_n  = exp_i;
    end else begin
      frac   = quot_i[23:1];
      guard  = quot_i[0];
      sticky = sticky_i;
      exp_n  = exp_i - 10'sd1;
    end
    round_up = guard & (sticky | frac[0]);
    // An all-ones fraction rounding up wraps to zero, i.e. the mantissa reloads 1.0.
    {carry, frac_rnd} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    exp_r       = carry ? (exp_n + 10'sd1) : exp_n;
    overflow_o  = (exp_r >= 10'sd255);
    underflow_o = (exp_r <= 10'sd0);
    if (overflow_o) begin
      result_o = {sign_i, POS_INF[30:0]};
    end else if (underflow_o) begin
      result_o = {sign_i, 31'd0};
    end else begin
      result_o = {sign_i, exp_r[EXP_W-1:0], frac_rnd};
    end
  end

endmodule

// File: rtl/fpu_32_divider_seq.sv
// Sequential binary32 divider: restoring mantissa division, one quotient bit per cycle,
// with special operands resolved at the accept edge. Denormal inputs are flushed to zero.
module fpu_32_divider_seq
  import fpu_32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic signed [9:0] EXP_BIAS = 10'(BIAS);

  div_state_e         state_q;
  logic [4:0]         cnt_q;
  logic [QUOT_W-1:0]  quot_q;
  logic [24:0]        rem_q;
  logic [23:0]        div_q;
  logic signed [9:0]  exp_q;
  logic               sign_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic               out_valid_q;

  logic               sa, sb, sq;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               spec_hit;
  logic [WIDTH-1:0]   spec_res;
  logic [3:0]         spec_flags;
  logic signed [9:0]  exp_d;

  logic               rem_ge;
  logic [24:0]        rem_sub;
  logic [24:0]        rem_d;
  logic [QUOT_W-1:0]  quot_d;

  logic [31:0]        rnd_res;
  logic               rnd_ovf;
  logic               rnd_unf;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Unpack operands and decide whether the operation resolves without dividing.
  always_comb begin
    sa = a[31];
    sb = b[31];
    sq = sa ^ sb;
    ea = a[30:23];
    eb = b[30:23];
    fa = a[22:0];
    fb = b[22:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;

    spec_hit   = 1'b1;
    spec_res   = QNAN;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_flags = pack_flags(1'b1, 1'b0, 1'b0, 1'b0);
    end else if (a_inf) begin
      spec_res = {sq, POS_INF[30:0]};
    end else if (b_inf) begin
      spec_res = {sq, 31'd0};
    end else if (b_zero) begin
      spec_res   = {sq, POS_INF[30:0]};
      spec_flags = pack_flags(1'b0, 1'b1, 1'b0, 1'b0);
    end else if (a_zero) begin
      spec_res = {sq, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring-division step: compare, conditionally subtract, shift.
  always_comb begin
    rem_ge  = (rem_q >= {1'b0, div_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    rem_d   = {rem_sub[23:0], 1'b0};
    quot_d  = {quot_q[QUOT_W-2:0], rem_ge};
  end

  fpu_32_div_round u_round (
    .sign_i      (sign_q),
    .quot_i      (quot_q),
    .sticky_i    (rem_q != '0),
    .exp_i       (exp_q),
    .result_o    (rnd_res),
    .overflow_o  (rnd_ovf),
    .underflow_o (rnd_unf)
  );

  // Control FSM with the datapath registers and the registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q <= sq;
            if (spec_hit) begin
              result_q    <= spec_res;
              flags_q     <= spec_flags;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              rem_q   <= {2'b01, fa};
              div_q   <= {1'b1, fb};
              quot_q  <= '0;
              exp_q   <= exp_d;
              cnt_q   <= 5'd25;
              state_q <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          if (cnt_q == 5'd0) begin
            state_q <= ST_ROUND;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ST_ROUND: begin
          result_q    <= rnd_res;
          flags_q     <= pack_flags(1'b0, 1'b0, rnd_ovf, rnd_unf);
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_32_divider_seq.sv
// Bench for fpu_32_divider_seq: directed cases, backpressure, mid-operation reset and
// randomized operands checked against an exact integer-arithmetic reference divider.
module tb_fpu_32_divider_seq;

  localparam int LAT_MAX = 60;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  fpu_32_divider_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference divider: exact quotient/remainder with round-to-nearest-even by comparison.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
    logic             s;
    logic [7:0]       ex, ey;
    logic [22:0]      fx, fy;
    longint unsigned  ma, mb, num, m, rem;
    int               e;
    s  = x[31] ^ y[31];
    ex = x[30:23];
    ey = y[30:23];
    fx = x[22:0];
    fy = y[22:0];
    f   = 4'b0000;
    lat = 0;
    r   = 32'h7FC00000;
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0)) begin
      r = 32'h7FC00000;
    end else if ((ex == 0 && ey == 0) || (ex == 8'hFF && ey == 8'hFF)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (ex == 8'hFF) begin
      r = {s, 8'hFF, 23'd0};
    end else if (ey == 8'hFF) begin
      r = {s, 31'd0};
    end else if (ey == 0) begin
      r = {s, 8'hFF, 23'd0};
      f = 4'b0100;
    end else if (ex == 0) begin
      r = {s, 31'd0};
    end else begin
      lat = 27;
      ma = 64'h800000 | 64'(fx);
      mb = 64'h800000 | 64'(fy);
      if (ma >= mb) begin
        num = ma << 23;
        e   = int'(ex) - int'(ey) + 127;
      end else begin
        num = ma << 24;
        e   = int'(ex) - int'(ey) + 126;
      end
      m   = num / mb;
      rem = num % mb;
      if ((2 * rem > mb) || ((2 * rem == mb) && m[0])) m = m + 1;
      if (m == (64'd1 << 24)) begin
        m = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 4'b0001;
      end else begin
        r = {s, e[7:0], m[22:0]};
      end
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0:       v[30:23] = 8'h00;
      1:       v[30:0]  = 31'd0;
      2:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      4, 5:    v[30:23] = 8'($urandom_range(235, 254));
      6, 7:    v[30:23] = 8'($urandom_range(1, 20));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Issue one operation, measure accept-to-valid latency, check and retire it.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [3:0] ef, input int elat,
                       input bit early, input string tag);
    int lat;
    check({tag, "/in_ready_before"}, 32'(in_ready), 32'd1);
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < LAT_MAX) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(elat));
    check({tag, "/result"}, result, er);
    check({tag, "/flags"}, 32'(flags), 32'(ef));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "/in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] x, y, er;
    logic [3:0]  ef;
    int          el;
    int          lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/result", result, 32'h0);
    check("reset/flags", 32'(flags), 32'd0);
    check("reset/in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 1'b0, "6div2");
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27, 1'b0, "1div3");
    do_op(32'h3F800000, 32'h41200000, 32'h3DCCCCCD, 4'b0000, 27, 1'b1, "1div10");
    do_op(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 0,  1'b0, "m1div0");
    do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0,  1'b0, "0div0");
    do_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0,  1'b1, "infdivinf");
    do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 0,  1'b0, "nan");
    do_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27, 1'b0, "overflow");
    do_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27, 1'b0, "underflow");
    do_op(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 0,  1'b0, "1divinf");
    do_op(32'hC0000000, 32'h00400000, 32'h7F800000 | 32'h80000000, 4'b0100, 0, 1'b0, "denormdiv");

    // Backpressure, with a competing request held during the whole busy period
    a        = 32'h40C00000;
    b        = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a   = 32'h3F800000;
    b   = 32'h3F800000;
    lat = 0;
    while (!out_valid && lat < LAT_MAX) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp/latency", 32'(lat), 32'd27);
    check("bp/result", result, 32'h40400000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp/hold_result", result, 32'h40400000);
      check("bp/hold_flags", 32'(flags), 32'd0);
      check("bp/hold_valid", 32'(out_valid), 32'd1);
      check("bp/hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp/released", 32'(in_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check("bp/no_capture", 32'(out_valid), 32'd0);

    // Reset in the middle of a divide
    a        = 32'h40C00000;
    b        = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/result", result, 32'h0);
    check("rst/flags", 32'(flags), 32'd0);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rst/no_stale_valid", 32'(out_valid), 32'd0);
    do_op(32'h40000000, 32'h40000000, 32'h3F800000, 4'b0000, 27, 1'b0, "after_rst");

    // Randomized operands
    for (int i = 0; i < 150; i++) begin
      x = rand_fp();
      y = rand_fp();
      ref_div(x, y, er, ef, el);
      do_op(x, y, er, ef, el, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_%h_%h", i, x, y));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_32_divider_seq.md
# fpu_32_divider_seq

Multi-cycle IEEE-754 single-precision divider, result = a / b, with valid/ready handshakes on both sides. It pairs with the combinational `fpu_32_reciprocal`: instead of 1/x in one combinational path, it computes the full quotient a·(1/b) iteratively in registers. It sits behind the FPU operand registers and feeds the FPU result mux.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands `a`, `b` are valid.
- `in_ready`  out  1  divider idle and accepting operands.
- `a`  in  WIDTH  dividend, IEEE-754 binary32.
- `b`  in  WIDTH  divisor, IEEE-754 binary32.
- `out_valid`  out  1  `result`/`flags` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  quotient, binary32.
- `flags`  out  4  {invalid, div_by_zero, overflow, underflow}.

## Operation
- FSM states: IDLE, DIVIDE, ROUND, DONE. `in_ready` = (state == IDLE).
- Accept: `in_valid && in_ready` at a clock edge. Unpack sign (sa^sb), exponents and mantissas with the hidden 1.
- Denormal inputs (exp == 0) are treated as signed zero (flush-to-zero).
- Special cases are resolved at the accept edge and go IDLE→DONE:
  - NaN on either input → 0x7FC00000, no flag.
  - 0/0 or inf/inf → 0x7FC00000, invalid.
  - finite nonzero / 0 → signed inf, div_by_zero.
  - 0 / finite nonzero → signed zero.
  - inf / finite → signed inf.
  - finite / inf → signed zero.
- Normal path, DIVIDE state: restoring division over 26 cycles.
  - Remainder starts at ma (24 bits) and is widened by 1 bit.
  - Each cycle: if r ≥ mb, the quotient bit is 1 and r −= mb; then r <<= 1.
  - A 5-bit counter runs 25 down to 0; q[25] is the integer bit.
- ROUND state:
  - If q[25] = 1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (r ≠ 0), e = ea − eb + 127.
  - Otherwise: mantissa = q[24:1], guard = q[0], sticky = (r ≠ 0), e = ea − eb + 126.
  - Round to nearest even. A mantissa carry-out increments e and reloads 1.0.
  - e is a 10-bit signed value.
  - e ≥ 255 → signed inf, overflow.
  - e ≤ 0 → signed zero, underflow (flush, no denormal output).
- DONE: `out_valid` = 1. `result`/`flags` are held stable until `out_valid && out_ready`, then the FSM returns to IDLE.

## Timing
- Reset values: `out_valid` 0, `result` 0x00000000, `flags` 0, state IDLE (so `in_ready` = 1), counter 0, quotient and remainder 0.
- Normal latency: accept at edge N; DIVIDE at edges N+1..N+26; ROUND at edge N+27. `out_valid` is high from edge N+27.
- Special-case latency: `out_valid` is high from edge N, the accept edge itself.
- The handshake completes on the edge where `out_valid && out_ready`. `in_ready` rises the same edge. A new accept can happen on the next edge at earliest; there is no overlap.
- `out_ready` held low: the result is held indefinitely and `in_ready` stays low.
- `in_valid` while busy is ignored; the operands are not captured.
- `out_ready` high before `out_valid` has no effect.
- `rst_n` low mid-operation: immediate asynchronous return to the reset values. The in-flight operation is discarded and no `out_valid` is produced.

## Structure
- Package `fpu_32_pkg`:
  - BIAS = 127, QNAN = 0x7FC00000, POS_INF = 0x7F800000.
  - Field widths: EXP_W = 8, MAN_W = 23.
  - Flag bit indices.
  - State enum.
- Sub-module `fpu_32_div_round`: combinational. Inputs: sign, 26-bit quotient, sticky, signed exponent. Outputs: packed result and overflow/underflow. Reusable by the multiplier.
- Everything else lives in `fpu_32_divider_seq`.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000, flags 0, `out_valid` exactly 27 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB. 0x3F800000 / 0x41200000 (1/10) → 0x3DCCCCCD (rounding up).
- 0xBF800000 / 0x00000000 → 0xFF800000, div_by_zero, `out_valid` from the accept edge. 0/0 → 0x7FC00000, invalid.
- 0x7F000000 / 0x3E800000 → 0x7F800000, overflow. 0x00800000 / 0x40000000 → 0x00000000, underflow.
- Backpressure: hold `out_ready` low 5 cycles after `out_valid` → `result`/`flags` unchanged, `in_ready` low, and a new `in_valid` is not captured.
- Assert `rst_n` at cycle 10 of a divide → all outputs at reset values, and the next operation 0x40000000 / 0x40000000 → 0x3F800000.
